// File: rtl/ultra_sonic_array.sv
// ultra_sonic_array
//   Round-robin driver for NUM_CH HC-SR04-class ultrasonic sensors. Only one
//   sensor is pinged at a time so echoes cannot cross-talk. Each echo pulse
//   width is measured in clk cycles (saturating, with timeout detection) and the
//   latest result per channel is kept in a small register bank for a bus read.
//
// Ports
//   clk          system clock (50 MHz nominal)
//   reset        asynchronous, active-high; clears all state immediately
//   enable       run the scan loop; stopping only takes effect after a holdoff
//   echo         raw asynchronous echo pins, one per sensor
//   trigger      trigger pins, one-hot or zero
//   rd_ch        bank entry to read
//   rd_en        read strobe, clears the 'new' flag of rd_ch
//   read_data    registered bank word: [31]=new [30]=timeout [COUNT_WIDTH-1:0]=count
//   sample_valid one-cycle pulse when a result is stored
//   sample_ch    channel of the stored result, valid with sample_valid
//   busy         scan FSM is not idle
module ultra_sonic_array #(
  parameter int NUM_CH         = 4,
  parameter int CH_W           = 2,
  parameter int COUNT_WIDTH    = 24,
  parameter int TRIG_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int HOLDOFF_CYCLES = 3000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] echo,
  output logic [NUM_CH-1:0] trigger,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic              rd_en,
  output logic [31:0]       read_data,
  output logic              sample_valid,
  output logic [CH_W-1:0]   sample_ch,
  output logic              busy
);

  // One shared phase timer covers the trigger pulse, the timeout window and the
  // holdoff gap, so it is sized for the longest of the three.
  localparam int MAX_A    = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_WAIT = (MAX_A > HOLDOFF_CYCLES) ? MAX_A : HOLDOFF_CYCLES;
  localparam int TMR_W    = $clog2(MAX_WAIT + 1);

  localparam logic [TMR_W-1:0] TRIG_LAST = TMR_W'(TRIG_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    WRITE,
    HOLDOFF
  } state_t;

  state_t                   state_q;
  logic [CH_W-1:0]          curCh_q;
  logic [TMR_W-1:0]         timer_q;
  logic [COUNT_WIDTH-1:0]   echoCnt_q;
  logic                     timedOut_q;
  logic [NUM_CH-1:0]        trigger_q;
  logic                     sampleValid_q;
  logic [CH_W-1:0]          sampleCh_q;
  logic                     busy_q;

  logic [NUM_CH-1:0]        echoMeta_q;
  logic [NUM_CH-1:0]        echoSync_q;

  logic                     bankNew_q [NUM_CH];
  logic                     bankTo_q  [NUM_CH];
  logic [COUNT_WIDTH-1:0]   bankCnt_q [NUM_CH];

  logic [31:0]              readData_q;
  logic [31:0]              readWord_d;
  logic [CH_W-1:0]          nextCh_d;
  logic                     echoS;

  // Two-flop synchronizer on every echo pin; only the active channel is looked at.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echoMeta_q <= '0;
      echoSync_q <= '0;
    end else begin
      echoMeta_q <= echo;
      echoSync_q <= echoMeta_q;
    end
  end

  assign echoS = echoSync_q[curCh_q];

  // Round-robin successor of the current channel.
  always_comb begin
    nextCh_d = curCh_q + 1'b1;
    if (curCh_q == CH_LAST) begin
      nextCh_d = '0;
    end
  end

  // Scan FSM. Outputs are registered and updated on the transitions.
  // WAIT_RISE checks the echo before the timeout, so an echo arriving on the
  // last window cycle still enters MEASURE; MEASURE therefore uses >= on the
  // timer to close the window one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      curCh_q       <= '0;
      timer_q       <= '0;
      echoCnt_q     <= '0;
      timedOut_q    <= 1'b0;
      trigger_q     <= '0;
      sampleValid_q <= 1'b0;
      sampleCh_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      sampleValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q   <= TRIG;
            trigger_q <= NUM_CH'(1) << curCh_q;
            timer_q   <= '0;
            busy_q    <= 1'b1;
          end
        end
        TRIG: begin
          echoCnt_q  <= '0;
          timedOut_q <= 1'b0;
          if (timer_q == TRIG_LAST) begin
            trigger_q <= '0;
            timer_q   <= '0;
            state_q   <= WAIT_RISE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        WAIT_RISE: begin
          if (echoS) begin
            echoCnt_q <= COUNT_WIDTH'(1);
            timer_q   <= timer_q + 1'b1;
            state_q   <= MEASURE;
          end else if (timer_q == TO_LAST) begin
            timedOut_q <= 1'b1;
            state_q    <= WRITE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        MEASURE: begin
          if (!echoS) begin
            state_q <= WRITE;
          end else if (timer_q >= TO_LAST) begin
            timedOut_q <= 1'b1;
            state_q    <= WRITE;
          end else begin
            timer_q <= timer_q + 1'b1;
            if (echoCnt_q != '1) begin
              echoCnt_q <= echoCnt_q + 1'b1;
            end
          end
        end
        WRITE: begin
          sampleValid_q <= 1'b1;
          sampleCh_q    <= curCh_q;
          timer_q       <= '0;
          state_q       <= HOLDOFF;
        end
        HOLDOFF: begin
          if (timer_q == HOLD_LAST) begin
            curCh_q <= nextCh_d;
            timer_q <= '0;
            if (enable) begin
              state_q   <= TRIG;
              trigger_q <= NUM_CH'(1) << nextCh_d;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          trigger_q <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // Result bank. A store in WRITE takes priority over a read-clear of the
  // same entry so a fresh result is never reported as already consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        bankNew_q[i] <= 1'b0;
        bankTo_q[i]  <= 1'b0;
        bankCnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (state_q == WRITE && int'(curCh_q) == i) begin
          bankNew_q[i] <= 1'b1;
          bankTo_q[i]  <= timedOut_q;
          bankCnt_q[i] <= echoCnt_q;
        end else if (rd_en && int'(rd_ch) == i) begin
          bankNew_q[i] <= 1'b0;
        end
      end
    end
  end

  // Bus word for the selected entry; out-of-range channels read as zero.
  always_comb begin
    readWord_d = '0;
    if (int'(rd_ch) < NUM_CH) begin
      readWord_d[31]               = bankNew_q[rd_ch];
      readWord_d[30]               = bankTo_q[rd_ch];
      readWord_d[COUNT_WIDTH-1:0]  = bankCnt_q[rd_ch];
    end
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readData_q <= '0;
    end else begin
      readData_q <= readWord_d;
    end
  end

  assign trigger      = trigger_q;
  assign read_data    = readData_q;
  assign sample_valid = sampleValid_q;
  assign sample_ch    = sampleCh_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_ultra_sonic_array.sv
// tb_ultra_sonic_array
//   Self-checking bench for ultra_sonic_array with small timing parameters.
//   A table of hand-derived pings and a batch of random pings are each
//   checked against an arithmetic model of the echo-width / timeout rules,
//   followed by hand sequences for read-clear, write/clear race, enable drop
//   and asynchronous reset.
module tb_ultra_sonic_array;

  localparam int NUM_CH         = 2;
  localparam int CH_W           = 1;
  localparam int COUNT_WIDTH    = 8;
  localparam int TRIG_CYCLES    = 10;
  localparam int TIMEOUT_CYCLES = 300;
  localparam int HOLDOFF_CYCLES = 50;
  localparam int NO_ECHO        = 1000;
  localparam int COUNT_MAX      = (1 << COUNT_WIDTH) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [NUM_CH-1:0] echo = '0;
  logic [NUM_CH-1:0] trigger;
  logic [CH_W-1:0]   rd_ch = '0;
  logic              rd_en = 1'b0;
  logic [31:0]       read_data;
  logic              sample_valid;
  logic [CH_W-1:0]   sample_ch;
  logic              busy;

  ultra_sonic_array #(
    .NUM_CH(NUM_CH),
    .CH_W(CH_W),
    .COUNT_WIDTH(COUNT_WIDTH),
    .TRIG_CYCLES(TRIG_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .echo(echo),
    .trigger(trigger),
    .rd_ch(rd_ch),
    .rd_en(rd_en),
    .read_data(read_data),
    .sample_valid(sample_valid),
    .sample_ch(sample_ch),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Free-running edge counter used to measure distances between events.
  int cycleNo = 0;
  always @(posedge clk) cycleNo <= cycleNo + 1;

  // Watch the trigger bus for more than one bit high at any sample point.
  int multiHot = 0;
  always @(negedge clk) begin
    if (!reset && $countones(trigger) > 1) multiHot <= multiHot + 1;
  end

  int compared   = 0;
  int mismatched = 0;
  int expCh      = 0;
  int lastWrite  = -1;

  typedef struct {
    int          ch;
    int          delay;
    int          width;
    logic [31:0] expWord;
  } vec_t;

  vec_t vecs [5];

  // Reference for one ping. The pin is driven high 'd' cycles after the
  // trigger-fall edge for 'p' cycles; two sync stages plus the sampling edge
  // make the FSM see it d+3 edges after the fall. The window closes
  // TIMEOUT_CYCLES edges after the fall; the result appears one edge after
  // the decision (doneK, counted in edges from the trigger fall).
  function automatic void model(input int d, input int p,
                                output logic [31:0] word, output int doneK);
    int   rise;
    int   cnt;
    logic to;
    rise = d + 3;
    if (rise > TIMEOUT_CYCLES) begin
      to = 1'b1; cnt = 0; doneK = TIMEOUT_CYCLES + 1;
    end else if (rise + p <= TIMEOUT_CYCLES) begin
      to = 1'b0; cnt = p; doneK = rise + p + 1;
    end else begin
      to = 1'b1; cnt = TIMEOUT_CYCLES - rise; doneK = TIMEOUT_CYCLES + 1;
    end
    if (cnt > COUNT_MAX) cnt = COUNT_MAX;
    word = 32'h8000_0000 | (to ? 32'h4000_0000 : 32'h0) | 32'(cnt);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d",
               name, actual, expected, cycleNo);
    end
  endtask

  task automatic reportTimeout(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: event did not occur within its cycle budget (cycle %0d)",
             name, cycleNo);
  endtask

  // One complete ping on channel ch: trigger checks, echo drive, result timing,
  // sample channel and bank contents. raceClear strobes rd_en on this channel
  // during the WRITE cycle; dropEnable releases enable while measuring.
  task automatic applyStimulus(input int ch, input int d, input int p,
                               input logic [31:0] expWord,
                               input bit raceClear, input bit dropEnable);
    int          n;
    int          riseCyc;
    int          fallCyc;
    int          doneK;
    bit          seen;
    logic [31:0] mWord;
    model(d, p, mWord, doneK);

    n = 0;
    while (trigger == '0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (trigger == '0) begin
      reportTimeout("trigger_rise");
      return;
    end
    riseCyc = cycleNo;
    checkOutput("trigger_channel", 32'(trigger), 32'(1) << ch);
    checkOutput("busy_in_ping", 32'(busy), 32'd1);
    if (lastWrite >= 0) checkOutput("holdoff_gap", 32'(riseCyc - lastWrite), 32'(HOLDOFF_CYCLES));

    n = 0;
    while (trigger != '0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (trigger != '0) begin
      reportTimeout("trigger_fall");
      return;
    end
    fallCyc = cycleNo;
    checkOutput("trigger_width", 32'(fallCyc - riseCyc), 32'(TRIG_CYCLES));

    seen = 1'b0;
    for (int k = 1; k <= 400 && !seen; k++) begin
      echo[ch] = (k > d) && (k <= d + p);
      rd_en    = raceClear && (k == doneK);
      if (raceClear) rd_ch = CH_W'(ch);
      if (dropEnable && k == d + 6) enable = 1'b0;
      @(posedge clk); #1;
      if (sample_valid) begin
        seen = 1'b1;
        checkOutput("sample_time", 32'(k), 32'(doneK));
      end
    end
    echo  = '0;
    rd_en = 1'b0;
    if (!seen) begin
      reportTimeout("sample_valid");
      return;
    end
    lastWrite = cycleNo;
    checkOutput("sample_ch", 32'(sample_ch), 32'(ch));

    rd_ch = CH_W'(ch);
    @(posedge clk); #1;
    checkOutput("bank_word", read_data, expWord);
    expCh = (ch + 1) % NUM_CH;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rWord;
    int          rDone;
    int          d;
    int          p;

    vecs[0] = '{ch: 0, delay: 20,      width: 100,  expWord: 32'h8000_0064};
    vecs[1] = '{ch: 1, delay: 20,      width: 70,   expWord: 32'h8000_0046};
    vecs[2] = '{ch: 0, delay: NO_ECHO, width: 0,    expWord: 32'hC000_0000};
    vecs[3] = '{ch: 1, delay: 0,       width: 2000, expWord: 32'hC000_00FF};
    vecs[4] = '{ch: 0, delay: 5,       width: 40,   expWord: 32'h8000_0028};

    // Reset state, observed while reset is still held.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_trigger", 32'(trigger), 32'd0);
    checkOutput("reset_read_data", read_data, 32'd0);
    checkOutput("reset_sample_valid", 32'(sample_valid), 32'd0);
    checkOutput("reset_sample_ch", 32'(sample_ch), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    rd_ch = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset_bank1", read_data, 32'd0);

    // First trigger follows the first edge that samples enable.
    enable = 1'b1;
    @(posedge clk); #1;
    checkOutput("first_trigger", 32'(trigger), 32'd1);

    for (int i = 0; i < 5; i++) begin
      $display("[TB] table ping %0d on ch%0d", i, vecs[i].ch);
      applyStimulus(vecs[i].ch, vecs[i].delay, vecs[i].width, vecs[i].expWord, 1'b0, 1'b0);
    end

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(7) == 0) d = NO_ECHO;
      else d = int'($urandom_range(250));
      p = int'($urandom_range(320, 1));
      model(d, p, rWord, rDone);
      applyStimulus(expCh, d, p, rWord, 1'b0, 1'b0);
    end

    // Read-clear on channel 0: the clearing cycle still reads new=1.
    if (expCh != 0) applyStimulus(expCh, 10, 30, 32'h8000_001E, 1'b0, 1'b0);
    applyStimulus(0, 15, 25, 32'h8000_0019, 1'b0, 1'b0);
    rd_ch = 1'b0;
    rd_en = 1'b1;
    @(posedge clk); #1;
    checkOutput("read_same_cycle", read_data, 32'h8000_0019);
    rd_en = 1'b0;
    @(posedge clk); #1;
    checkOutput("read_after_clear", read_data, 32'h0000_0019);

    // Write and clear of channel 0 in the same cycle: the write wins.
    applyStimulus(1, 10, 30, 32'h8000_001E, 1'b0, 1'b0);
    applyStimulus(0, 12, 33, 32'h8000_0021, 1'b1, 1'b0);

    // Drop enable mid-measurement on channel 0; the result is still stored.
    applyStimulus(1, 30, 10, 32'h8000_000A, 1'b0, 1'b0);
    applyStimulus(0, 5, 60, 32'h8000_003C, 1'b0, 1'b1);
    repeat (48) @(posedge clk);
    #1;
    checkOutput("busy_late_holdoff", 32'(busy), 32'd1);
    @(posedge clk); #1;
    checkOutput("busy_after_stop", 32'(busy), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("idle_trigger", 32'(trigger), 32'd0);
    lastWrite = -1;
    enable = 1'b1;
    @(posedge clk); #1;
    checkOutput("reenable_next_ch", 32'(trigger), 32'd2);

    // Asynchronous reset in the middle of the trigger pulse.
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_trigger", 32'(trigger), 32'd0);
    checkOutput("async_reset_busy", 32'(busy), 32'd0);
    checkOutput("async_reset_read_data", read_data, 32'd0);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rd_ch = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_reset_bank0", read_data, 32'd0);
    rd_ch = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_reset_bank1", read_data, 32'd0);

    checkOutput("trigger_onehot", 32'(multiHot), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
